// File: rtl/alu_sequencer.sv
// Multi-cycle ALU instruction sequencer: IDLE -> READ -> EXEC -> WB.
// Reads operands, drives the ALU, writes the result back and maintains the PSR.
module alu_sequencer #(
    parameter logic [4:0] NOP_OP = 5'b11111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [3:0]  cmd_rdest,
    input  logic [3:0]  cmd_rsrc,
    input  logic        cmd_imm_en,
    input  logic [7:0]  cmd_imm,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_rdest,
    output logic [15:0] alu_rsrc,
    output logic [4:0]  alu_opcode,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] OpAdd = 5'd0;
    localparam logic [4:0] OpSub = 5'd1;
    localparam logic [4:0] OpCmp = 5'd2;
    localparam logic [4:0] OpMax = 5'd9;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [4:0]  op_q;
    logic [3:0]  rdest_q, rsrc_q;
    logic        imm_en_q;
    logic [7:0]  imm_q;
    logic [15:0] alu_rdest_q, alu_rsrc_q, res_q;
    logic [4:0]  alu_opcode_q, flags_q, psr_q, psr_d;
    logic        done_q, err_q, rf_we_q;
    logic        op_legal;

    assign op_legal = (op_q <= OpMax);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // CMP only refreshes N, Z and L; carry and overflow keep the last arithmetic result.
    always_comb begin
        psr_d = psr_q;
        if (state_q == StWb && !err_q) begin
            if (op_q == OpAdd || op_q == OpSub) begin
                psr_d = flags_q;
            end else if (op_q == OpCmp) begin
                psr_d = {flags_q[4], flags_q[3], psr_q[2], flags_q[1], psr_q[0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            psr_q        <= 5'd0;
            alu_rdest_q  <= 16'd0;
            alu_rsrc_q   <= 16'd0;
            alu_opcode_q <= NOP_OP;
            res_q        <= 16'd0;
            flags_q      <= 5'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rf_we_q      <= 1'b0;
            op_q         <= 5'd0;
            rdest_q      <= 4'd0;
            rsrc_q       <= 4'd0;
            imm_en_q     <= 1'b0;
            imm_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            psr_q        <= psr_d;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rf_we_q      <= 1'b0;
            alu_opcode_q <= NOP_OP;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        rdest_q  <= cmd_rdest;
                        rsrc_q   <= cmd_rsrc;
                        imm_en_q <= cmd_imm_en;
                        imm_q    <= cmd_imm;
                    end
                end
                StRead: begin
                    alu_rdest_q  <= rf_rdata_a;
                    alu_rsrc_q   <= imm_en_q ? {{8{imm_q[7]}}, imm_q} : rf_rdata_b;
                    alu_opcode_q <= op_legal ? op_q : NOP_OP;
                end
                StExec: begin
                    res_q   <= alu_out;
                    flags_q <= alu_flags;
                    done_q  <= 1'b1;
                    err_q   <= !op_legal;
                    rf_we_q <= op_legal && (op_q != OpCmp);
                end
                StWb: begin
                end
                default: begin
                end
            endcase
        end
    end

    // A reset sampled at the end of WB must suppress the write and the retire pulse.
    assign cmd_ready  = (state_q == StIdle) && reset_n;
    assign rf_raddr_a = rdest_q;
    assign rf_raddr_b = rsrc_q;
    assign rf_we      = rf_we_q && reset_n;
    assign rf_waddr   = rdest_q;
    assign rf_wdata   = res_q;
    assign alu_rdest  = alu_rdest_q;
    assign alu_rsrc   = alu_rsrc_q;
    assign alu_opcode = alu_opcode_q;
    assign psr        = psr_q;
    assign done       = done_q && reset_n;
    assign err        = err_q && reset_n;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_imm_en;
    logic [4:0]  cmd_op;
    logic [3:0]  cmd_rdest, cmd_rsrc;
    logic [7:0]  cmd_imm;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_rdest, alu_rsrc, alu_out;
    logic [4:0]  alu_opcode, alu_flags, psr;
    logic        done, err;

    logic [15:0] rf [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_waddr = 4'd0;
    logic [15:0] tb_wdata = 16'd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.NOP_OP(5'b11111)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags), .psr(psr), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (tb_we) rf[tb_waddr] <= tb_wdata;
    end
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    // ALU model; flags {N,Z,F,L,C}. NOP returns all-ones flags so a stray PSR load shows.
    always_comb begin
        logic [16:0] s;
        logic        n, z, f, l, c;
        s = 17'd0; n = 1'b0; z = 1'b0; f = 1'b0; l = 1'b0; c = 1'b0;
        alu_out = 16'hDEAD;
        case (alu_opcode)
            5'd0: begin
                s = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
                alu_out = s[15:0]; c = s[16];
                f = (alu_rdest[15] == alu_rsrc[15]) && (s[15] != alu_rdest[15]);
            end
            5'd1: begin
                alu_out = alu_rdest - alu_rsrc; c = alu_rdest < alu_rsrc;
                f = (alu_rdest[15] != alu_rsrc[15]) && (alu_out[15] != alu_rdest[15]);
            end
            5'd2: alu_out = alu_rdest - alu_rsrc;
            5'd5: alu_out = alu_rdest ^ alu_rsrc;
            default: alu_out = 16'hDEAD;
        endcase
        n = alu_out[15];
        z = (alu_out == 16'd0);
        if (alu_opcode == 5'd2) begin
            n = $signed(alu_rdest) < $signed(alu_rsrc);
            z = (alu_rdest == alu_rsrc);
            l = alu_rdest < alu_rsrc;
        end
        alu_flags = (alu_opcode > 5'd9) ? 5'b11111 : {n, z, f, l, c};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rf_load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Presents one command in IDLE and returns just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic ie, input logic [7:0] imm);
        @(negedge clk);
        cmd_op = op; cmd_rdest = rd; cmd_rsrc = rs; cmd_imm_en = ie; cmd_imm = imm;
        cmd_valid = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    int acc[3];
    int dn[3];
    int nacc, nd;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 5'd0; cmd_rdest = 4'd0;
        cmd_rsrc = 4'd0; cmd_imm_en = 1'b0; cmd_imm = 8'd0;
        for (int i = 0; i < 16; i++) rf[i] = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", cmd_ready, 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_psr", psr, 0);
        chk("reset_done", done, 0);
        chk("reset_we", rf_we, 0);
        chk("reset_opa", alu_rdest, 0);
        chk("reset_opcode", alu_opcode, 5'b11111);

        rf_load(4'd1, 16'h8000); rf_load(4'd2, 16'hFFFF);
        rf_load(4'd3, 16'd5);    rf_load(4'd4, 16'd5);
        rf_load(4'd5, 16'h0010);

        // ADD R1,R2 with carry and overflow
        send(5'd0, 4'd1, 4'd2, 1'b0, 8'd0);
        @(negedge clk);
        chk("add_read_ready", cmd_ready, 0);
        chk("add_read_done", done, 0);
        @(negedge clk);
        chk("add_exec_done", done, 0);
        chk("add_exec_opa", alu_rdest, 16'h8000);
        @(negedge clk);
        chk("add_wb_done", done, 1);
        chk("add_wb_we", rf_we, 1);
        chk("add_wb_wdata", rf_wdata, 16'h7FFF);
        @(negedge clk);
        chk("add_r1", rf[1], 16'h7FFF);
        chk("add_psr", psr, 5'b00101);
        chk("add_ready_back", cmd_ready, 1);

        // CMP R3,R4 equal: Z set, C/F held
        send(5'd2, 4'd3, 4'd4, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        chk("cmp1_done", done, 1);
        chk("cmp1_we", rf_we, 0);
        @(negedge clk);
        chk("cmp1_psr", psr, 5'b01101);
        rf_load(4'd4, 16'd9);
        send(5'd2, 4'd4, 4'd3, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        chk("cmp2_we", rf_we, 0);
        @(negedge clk);
        chk("cmp2_psr", psr, 5'b00101);
        chk("cmp2_r4", rf[4], 16'd9);

        // SUB R5, imm 0xFF (-1)
        send(5'd1, 4'd5, 4'd0, 1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        chk("sub_exec_opb", alu_rsrc, 16'hFFFF);
        chk("sub_exec_opcode", alu_opcode, 5'd1);
        @(negedge clk);
        chk("sub_wb_wdata", rf_wdata, 16'h0011);
        @(negedge clk);
        chk("sub_r5", rf[5], 16'h0011);
        chk("sub_psr", psr, 5'b00001);

        // Illegal opcode 10
        send(5'b01010, 4'd1, 4'd2, 1'b0, 8'd0);
        @(negedge clk);
        chk("ill_read_we", rf_we, 0);
        @(negedge clk);
        chk("ill_exec_opcode", alu_opcode, 5'b11111);
        chk("ill_exec_we", rf_we, 0);
        @(negedge clk);
        chk("ill_wb_done", done, 1);
        chk("ill_wb_err", err, 1);
        chk("ill_wb_we", rf_we, 0);
        @(negedge clk);
        chk("ill_psr", psr, 5'b00001);
        chk("ill_r1", rf[1], 16'h7FFF);

        // Reset during EXEC of an ADD aborts it
        send(5'd0, 4'd1, 4'd2, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_psr", psr, 0);
        chk("rst_opb", alu_rsrc, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        chk("rst_r1", rf[1], 16'h7FFF);

        // Three back-to-back XOR R1,R2 with cmd_valid held
        nacc = 0; nd = 0;
        @(negedge clk);
        cmd_op = 5'd5; cmd_rdest = 4'd1; cmd_rsrc = 4'd2; cmd_imm_en = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (cmd_valid && cmd_ready && nacc < 3) acc[nacc++] = i;
            if (done && nd < 3) dn[nd++] = i;
            @(posedge clk);
            #1 if (nacc == 3) cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("xor_accepts", nacc, 3);
        chk("xor_dones", nd, 3);
        if (nacc == 3 && nd == 3) begin
            chk("xor_acc_gap1", acc[1] - acc[0], 4);
            chk("xor_acc_gap2", acc[2] - acc[1], 4);
            chk("xor_latency", dn[0] - acc[0], 3);
            chk("xor_done_gap1", dn[1] - dn[0], 4);
            chk("xor_done_gap2", dn[2] - dn[1], 4);
        end
        chk("xor_r1", rf[1], 16'h8000);
        chk("xor_psr", psr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
